exec_unit: RTL
==============

# exec_unit

Parametrised integer execution unit for the core's issue stage, replacing the single-cycle unit1 datapath. Resolves branches and jumps, executes single-cycle ALU ops with registered writeback, and adds an iterative multiply/divide engine with a busy handshake and flush support. Branch results feed fetch; the two writeback ports feed the register file and forwarding network.

## Interface
- DATA_W, 32: operand/result width (≥8, even)
- PC_W, 14: program counter width (≤ IMM_W)
- IMM_W, 16: immediate width; sign-extended to DATA_W
- RADDR_W, 6: destination register address width; address 0 means no write
- LINK_REG, 31: destination of JAL/JALR link value

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- pc  in  PC_W  PC of issued op
- ope  in  6  opcode; 0 = bubble
- ds_val, dt_val  in  DATA_W  source operands
- dd  in  RADDR_W  destination register
- imm  in  IMM_W  immediate
- opr  in  5  signed compare constant for compare-with-immediate branches
- ctrl  in  4  bit0 = predicted taken; bits 3:1 reserved
- flush  in  1  squash in-flight mul/div
- is_busy  out  1  mul/div engine occupied
- b_is_hazard, b_is_b_ope, b_is_branch  out  1  mispredict/redirect, conditional-branch flag, actual taken
- b_addr  out  PC_W  redirect target
- b_w_pc  out  PC_W  PC of resolved op
- alu_addr  out  RADDR_W; alu_dd_val  out  DATA_W  ALU/link writeback
- md_addr  out  RADDR_W; md_dd_val  out  DATA_W  mul/div writeback

## Operation
- Opcodes unchanged from the current ISA: LUI 110000, ADD 001100, ADDI 001000, SUB 010100, SLL/SLLI 011100/011000, SRL/SRLI 100100/100000, SRA/SRAI 101100/101000, J 000010, JAL 000110, JR 001010, JALR 001110, BEQ 010010, BLE 011010, BEQI 110010, BNEI 111010, BLEI 100010, BGTI 101010. New: MUL 110100 (low DATA_W bits of ds*dt), DIVU 111100 (unsigned ds/dt), REMU 111000 (unsigned ds%dt).
- ALU: ope[2]=1 selects dt_val, else sign-extended imm; shift amount = low log2(DATA_W) bits; add/sub wrap mod 2^DATA_W. LUI = {imm, ds_val[DATA_W-IMM_W-1:0]}.
- JAL/JALR write pc+1 (zero-extended) to LINK_REG; other non-ALU ops write alu_addr=0.
- Branches: taken per opcode compare (signed); b_is_hazard = JR|JALR|(cond branch & taken≠ctrl[0]); b_addr = ds_val[PC_W-1:0] for J/JR class, imm[PC_W-1:0] if taken, else pc+1 (mod 2^PC_W).
- Mul/div FSM (IDLE, RUN, DONE): MUL/DIVU/REMU accepted only in IDLE or DONE; captures operands, dd, op → RUN. RUN iterates one bit/cycle, DATA_W cycles (shift-add multiply; restoring divide). → DONE: md_addr/md_dd_val valid one cycle, then IDLE unless a new op is accepted that cycle.
- Divide by zero: DIVU → all ones; REMU → ds_val. No exception.
- Mul/div op issued while RUN: dropped, no writeback (issuer must honour is_busy).
- flush: RUN/DONE → IDLE next cycle, md_addr forced 0; flush with simultaneous mul/div issue: issue dropped.
- md_addr = 0 except in DONE.

## Timing
- All outputs registered; reset value 0 for every output; FSM → IDLE.
- ALU and branch latency: 1 cycle (issue in cycle t → outputs valid t+1).
- Mul/div: issue t → is_busy high t+1..t+DATA_W → md result valid t+DATA_W+1 (is_busy low that cycle; back-to-back issue accepted).
- ALU and md writeback may be valid in the same cycle; no arbitration here.
- Reset mid-RUN: abandons op, no writeback.

## Structure
- exec_pkg: opcode localparams, FSM state enum, op-class decode functions (is_alu, is_cond_branch, is_md).
- Sub-module muldiv_iter: iterative engine with start/flush/done, parametrised by DATA_W; exec_unit holds decode, ALU, branch logic, registers.

## Test plan
- ADD ds=5, dt=-7, dd=3 → next cycle alu_addr=3, alu_dd_val=0xFFFFFFFE.
- BEQ ds=dt=9, ctrl[0]=0, imm=0x0123 → b_is_hazard=1, b_is_branch=1, b_addr=0x0123.
- JALR pc=0x3FFF, ds=0x0040 → b_addr=0x0040, alu_addr=31, alu_dd_val=0x4000 (PC wraps only in b_addr).
- MUL 7×6, dd=5 at t → is_busy t+1..t+32, md_addr=5, md_dd_val=42 at t+33; new DIVU 100/7 issued t+33 → 14 at t+66.
- DIVU 123/0 → 0xFFFFFFFF; REMU 123/0 → 123.
- DIVU started, flush at t+10 → is_busy 0 at t+11, md_addr stays 0; rstn low mid-RUN → same.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcode map, mul/div FSM states and op-class decode for the integer execution unit.
package exec_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_LUI  = 6'b110000;
    localparam logic [5:0] OP_ADD  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUB  = 6'b010100;
    localparam logic [5:0] OP_SLL  = 6'b011100;
    localparam logic [5:0] OP_SLLI = 6'b011000;
    localparam logic [5:0] OP_SRL  = 6'b100100;
    localparam logic [5:0] OP_SRLI = 6'b100000;
    localparam logic [5:0] OP_SRA  = 6'b101100;
    localparam logic [5:0] OP_SRAI = 6'b101000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000110;
    localparam logic [5:0] OP_JR   = 6'b001010;
    localparam logic [5:0] OP_JALR = 6'b001110;
    localparam logic [5:0] OP_BEQ  = 6'b010010;
    localparam logic [5:0] OP_BLE  = 6'b011010;
    localparam logic [5:0] OP_BEQI = 6'b110010;
    localparam logic [5:0] OP_BNEI = 6'b111010;
    localparam logic [5:0] OP_BLEI = 6'b100010;
    localparam logic [5:0] OP_BGTI = 6'b101010;
    localparam logic [5:0] OP_MUL  = 6'b110100;
    localparam logic [5:0] OP_DIVU = 6'b111100;
    localparam logic [5:0] OP_REMU = 6'b111000;

    localparam logic [1:0] MD_MUL  = 2'd0;
    localparam logic [1:0] MD_DIVU = 2'd1;
    localparam logic [1:0] MD_REMU = 2'd2;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_alu(input logic [5:0] ope);
        case (ope)
            OP_LUI, OP_ADD, OP_ADDI, OP_SUB, OP_SLL, OP_SLLI,
            OP_SRL, OP_SRLI, OP_SRA, OP_SRAI: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_cond_branch(input logic [5:0] ope);
        case (ope)
            OP_BEQ, OP_BLE, OP_BEQI, OP_BNEI, OP_BLEI, OP_BGTI: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_jump(input logic [5:0] ope);
        case (ope)
            OP_J, OP_JAL, OP_JR, OP_JALR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_link(input logic [5:0] ope);
        return (ope == OP_JAL) || (ope == OP_JALR);
    endfunction

    function automatic logic is_md(input logic [5:0] ope);
        return (ope == OP_MUL) || (ope == OP_DIVU) || (ope == OP_REMU);
    endfunction

    function automatic logic [1:0] md_op_of(input logic [5:0] ope);
        case (ope)
            OP_DIVU: return MD_DIVU;
            OP_REMU: return MD_REMU;
            default: return MD_MUL;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative one-bit-per-cycle multiply (shift-add) and unsigned divide (restoring).
//   state   | meaning
//   MD_IDLE | no op in flight, ready to accept
//   MD_RUN  | iterating, DATA_W cycles, busy
//   MD_DONE | result valid for one cycle, may accept the next op
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              flush_i,
    output logic              accept_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);
    localparam int CNT_W = $clog2(DATA_W);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    // acc: product or partial remainder; opb: multiplicand or divisor;
    // opc: multiplier or dividend shifting out while quotient shifts in
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] opc_q, opc_d;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   diff;

    assign accept_o = start_i && !flush_i && (state_q != MD_RUN);
    assign busy_o   = (state_q == MD_RUN);
    assign done_o   = (state_q == MD_DONE);
    assign result_o = (op_q == MD_DIVU) ? opc_q : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        rem_sh  = {acc_q, opc_q[DATA_W-1]};
        diff    = rem_sh - {1'b0, opb_q};

        unique case (state_q)
            MD_IDLE: ;
            MD_RUN: begin
                if (op_q == MD_MUL) begin
                    if (opc_q[0]) acc_d = acc_q + opb_q;
                    opb_d = opb_q << 1;
                    opc_d = opc_q >> 1;
                end else if (!diff[DATA_W]) begin
                    acc_d = diff[DATA_W-1:0];
                    opc_d = {opc_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[DATA_W-1:0];
                    opc_d = {opc_q[DATA_W-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = MD_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase

        if (accept_o) begin
            state_d = MD_RUN;
            cnt_d   = CNT_W'(DATA_W - 1);
            op_d    = op_i;
            acc_d   = '0;
            // a zero divisor naturally yields all-ones quotient and remainder = dividend
            opb_d   = (op_i == MD_MUL) ? a_i : b_i;
            opc_d   = (op_i == MD_MUL) ? b_i : a_i;
        end
        if (flush_i) state_d = MD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MUL;
            acc_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Issue-stage integer execution unit: branch/jump resolution, single-cycle ALU with
// registered writeback, and an iterative mul/div engine with busy handshake and flush.
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 14,
    parameter int IMM_W    = 16,
    parameter int RADDR_W  = 6,
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [PC_W-1:0]    pc,
    input  logic [5:0]         ope,
    input  logic [DATA_W-1:0]  ds_val,
    input  logic [DATA_W-1:0]  dt_val,
    input  logic [RADDR_W-1:0] dd,
    input  logic [IMM_W-1:0]   imm,
    input  logic [4:0]         opr,
    input  logic [3:0]         ctrl,
    input  logic               flush,
    output logic               is_busy,
    output logic               b_is_hazard,
    output logic               b_is_b_ope,
    output logic               b_is_branch,
    output logic [PC_W-1:0]    b_addr,
    output logic [PC_W-1:0]    b_w_pc,
    output logic [RADDR_W-1:0] alu_addr,
    output logic [DATA_W-1:0]  alu_dd_val,
    output logic [RADDR_W-1:0] md_addr,
    output logic [DATA_W-1:0]  md_dd_val
);
    localparam int SHW = $clog2(DATA_W);

    logic [DATA_W-1:0]  imm_ext, opr_ext, op_b, alu_res;
    logic [SHW-1:0]     shamt;
    logic               cond, jump, taken;

    logic               b_is_hazard_q, b_is_hazard_d;
    logic               b_is_b_ope_q, b_is_b_ope_d;
    logic               b_is_branch_q, b_is_branch_d;
    logic [PC_W-1:0]    b_addr_q, b_addr_d;
    logic [PC_W-1:0]    b_w_pc_q, b_w_pc_d;
    logic [RADDR_W-1:0] alu_addr_q, alu_addr_d;
    logic [DATA_W-1:0]  alu_dd_val_q, alu_dd_val_d;
    logic [RADDR_W-1:0] md_tag_q, md_tag_d;

    logic               md_start, md_accept, md_done;
    logic [1:0]         md_op;
    logic [DATA_W-1:0]  md_result;
    logic               unused_ctrl;

    assign unused_ctrl = ^ctrl[3:1];

    always_comb begin
        imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        opr_ext = {{(DATA_W-5){opr[4]}}, opr};
        op_b    = ope[2] ? dt_val : imm_ext;
        shamt   = op_b[SHW-1:0];
        case (ope)
            OP_LUI:           alu_res = {imm, ds_val[DATA_W-IMM_W-1:0]};
            OP_ADD, OP_ADDI:  alu_res = ds_val + op_b;
            OP_SUB:           alu_res = ds_val - op_b;
            OP_SLL, OP_SLLI:  alu_res = ds_val << shamt;
            OP_SRL, OP_SRLI:  alu_res = ds_val >> shamt;
            OP_SRA, OP_SRAI:  alu_res = $unsigned($signed(ds_val) >>> shamt);
            default:          alu_res = '0;
        endcase
    end

    always_comb begin
        cond = is_cond_branch(ope);
        jump = is_jump(ope);
        case (ope)
            OP_BEQ:  taken = (ds_val == dt_val);
            OP_BLE:  taken = ($signed(ds_val) <= $signed(dt_val));
            OP_BEQI: taken = (ds_val == opr_ext);
            OP_BNEI: taken = (ds_val != opr_ext);
            OP_BLEI: taken = ($signed(ds_val) <= $signed(opr_ext));
            OP_BGTI: taken = ($signed(ds_val) >  $signed(opr_ext));
            default: taken = 1'b0;
        endcase

        b_is_b_ope_d  = cond;
        b_is_branch_d = jump || (cond && taken);
        // J/JAL are redirected at fetch; only register-indirect jumps and mispredicts flush
        b_is_hazard_d = (ope == OP_JR) || (ope == OP_JALR) || (cond && (taken != ctrl[0]));
        if (jump)              b_addr_d = ds_val[PC_W-1:0];
        else if (cond && taken) b_addr_d = imm[PC_W-1:0];
        else                   b_addr_d = pc + PC_W'(1);
        b_w_pc_d = pc;

        if (is_alu(ope)) begin
            alu_addr_d   = dd;
            alu_dd_val_d = alu_res;
        end else if (is_link(ope)) begin
            alu_addr_d   = RADDR_W'(LINK_REG);
            alu_dd_val_d = DATA_W'(pc) + DATA_W'(1);
        end else begin
            alu_addr_d   = '0;
            alu_dd_val_d = '0;
        end

        md_start = is_md(ope);
        md_op    = md_op_of(ope);
        md_tag_d = md_accept ? dd : md_tag_q;
    end

    muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
        .clk      (clk),
        .rstn     (rstn),
        .start_i  (md_start),
        .op_i     (md_op),
        .a_i      (ds_val),
        .b_i      (dt_val),
        .flush_i  (flush),
        .accept_o (md_accept),
        .busy_o   (is_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            b_is_hazard_q <= 1'b0;
            b_is_b_ope_q  <= 1'b0;
            b_is_branch_q <= 1'b0;
            b_addr_q      <= '0;
            b_w_pc_q      <= '0;
            alu_addr_q    <= '0;
            alu_dd_val_q  <= '0;
            md_tag_q      <= '0;
        end else begin
            b_is_hazard_q <= b_is_hazard_d;
            b_is_b_ope_q  <= b_is_b_ope_d;
            b_is_branch_q <= b_is_branch_d;
            b_addr_q      <= b_addr_d;
            b_w_pc_q      <= b_w_pc_d;
            alu_addr_q    <= alu_addr_d;
            alu_dd_val_q  <= alu_dd_val_d;
            md_tag_q      <= md_tag_d;
        end
    end

    assign b_is_hazard = b_is_hazard_q;
    assign b_is_b_ope  = b_is_b_ope_q;
    assign b_is_branch = b_is_branch_q;
    assign b_addr      = b_addr_q;
    assign b_w_pc      = b_w_pc_q;
    assign alu_addr    = alu_addr_q;
    assign alu_dd_val  = alu_dd_val_q;
    assign md_addr     = md_done ? md_tag_q : '0;
    assign md_dd_val   = md_done ? md_result : '0;

endmodule
